// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: assembles sof-framed bit streams into
// WIDTH-bit words and holds each in an output register until the consumer takes it.
//
// state | meaning
// IDLE  | no word in progress; waiting for a bit flagged with sof
// SHIFT | collecting bits 1..WIDTH-1 of the current word
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             busy,
    output logic             ovf,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             dout_vld_nxt;
    logic             ovf_nxt;
    logic             frame_err_nxt;
    logic             word_done;
    logic             load;

    // Capturing bit 0 is a shift into a cleared register, so the first bit
    // walks to dout[WIDTH-1] (MSB first) or dout[0] (LSB first) after WIDTH bits.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
        if (MSB_FIRST)
            return {base[WIDTH-2:0], b};
        else
            return {b, base[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sreg_nxt      = sreg;
        frame_err_nxt = 1'b0;
        word_done     = 1'b0;
        case (state)
            IDLE: begin
                if (sin_vld && sof) begin
                    sreg_nxt  = shift_in('0, sin);
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_vld) begin
                    if (sof) begin
                        frame_err_nxt = 1'b1;
                        sreg_nxt      = shift_in('0, sin);
                        cnt_nxt       = CW'(1);
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        sreg_nxt  = shift_in(sreg, sin);
                        cnt_nxt   = '0;
                        word_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        sreg_nxt = shift_in(sreg, sin);
                        cnt_nxt  = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A word may load if the output register is empty or being drained this edge.
        load         = word_done && (!dout_vld || dout_rdy);
        ovf_nxt      = word_done && dout_vld && !dout_rdy;
        dout_nxt     = load ? sreg_nxt : dout;
        dout_vld_nxt = load || (dout_vld && !dout_rdy);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sreg      <= sreg_nxt;
            dout      <= dout_nxt;
            dout_vld  <= dout_vld_nxt;
            ovf       <= ovf_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed scenarios plus random traffic, both bit orders,
// checked every cycle against a word-level model built from collected bit lists.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sin = 1'b0;
    logic       sin_vld = 1'b0;
    logic       sof = 1'b0;
    logic       dout_rdy = 1'b1;
    logic [7:0] dout_m, dout_l;
    logic       vld_m, vld_l, busy_m, busy_l, ovf_m, ovf_l, fe_m, fe_l;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn), .sin(sin), .sin_vld(sin_vld), .sof(sof),
        .dout(dout_m), .dout_vld(vld_m), .dout_rdy(dout_rdy),
        .busy(busy_m), .ovf(ovf_m), .frame_err(fe_m)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn), .sin(sin), .sin_vld(sin_vld), .sof(sof),
        .dout(dout_l), .dout_vld(vld_l), .dout_rdy(dout_rdy),
        .busy(busy_l), .ovf(ovf_l), .frame_err(fe_l)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: bits of the open word kept as a list in arrival order.
    bit         q[$];
    bit         m_busy, m_vld, m_ovf, m_fe, started;
    logic [7:0] m_dm, m_dl;
    int         ferr_seen = 0;

    always @(posedge clk) begin
        bit         done;
        logic [7:0] wm, wl;
        started = 1'b1;
        done    = 1'b0;
        wm      = '0;
        wl      = '0;
        if (!rstn) begin
            q.delete();
            m_busy = 0; m_vld = 0; m_ovf = 0; m_fe = 0;
            m_dm = '0; m_dl = '0;
        end else begin
            m_ovf = 0;
            m_fe  = 0;
            if (sin_vld) begin
                if (sof) begin
                    if (m_busy) m_fe = 1;
                    q.delete();
                    q.push_back(sin);
                    m_busy = 1;
                end else if (m_busy) begin
                    q.push_back(sin);
                    if (q.size() == 8) begin
                        for (int i = 0; i < 8; i++) begin
                            wm[7-i] = q[i];
                            wl[i]   = q[i];
                        end
                        done = 1;
                        q.delete();
                        m_busy = 0;
                    end
                end
            end
            if (done) begin
                if (!m_vld || dout_rdy) begin
                    m_dm  = wm;
                    m_dl  = wl;
                    m_vld = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_vld && dout_rdy) begin
                m_vld = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("dout_msb", dout_m, m_dm);
            chk("dout_lsb", dout_l, m_dl);
            chk("vld_msb", vld_m, m_vld);
            chk("vld_lsb", vld_l, m_vld);
            chk("busy_msb", busy_m, m_busy);
            chk("busy_lsb", busy_l, m_busy);
            chk("ovf_msb", ovf_m, m_ovf);
            chk("ovf_lsb", ovf_l, m_ovf);
            chk("ferr_msb", fe_m, m_fe);
            chk("ferr_lsb", fe_l, m_fe);
            if (fe_m) ferr_seen++;
        end
    end

    // Sends w most-significant bit first, sof on the first bit, gap idle cycles after each bit.
    task automatic send_word(input logic [7:0] w, input int gap);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sin = w[7-i]; sof = (i == 0); sin_vld = 1'b1;
            if (i < 7) begin
                repeat (gap) begin
                    @(negedge clk);
                    sin_vld = 1'b0; sof = 1'b0;
                end
            end
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin = 1'($urandom); sof = (i == 0); sin_vld = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sin_vld = 1'b0; sof = 1'b0;
        end
    endtask

    initial begin
        int f0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout", dout_m, 8'h00);
        chk("rst_vld", vld_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        rstn = 1'b1;

        send_word(8'hA5, 0);
        idle(1); #1;
        chk("a5_dout", dout_m, 8'hA5);
        chk("a5_dout_lsb", dout_l, 8'hA5);
        chk("a5_vld", vld_m, 1'b1);
        chk("a5_model", m_dm, 8'hA5);
        idle(1); #1;
        chk("a5_vld_clr", vld_m, 1'b0);

        send_word(8'hC0, 0);
        idle(1); #1;
        chk("c0_msb", dout_m, 8'hC0);
        chk("c0_lsb_03", dout_l, 8'h03);
        chk("c0_model_lsb", m_dl, 8'h03);
        idle(1);

        dout_rdy = 1'b0;
        send_word(8'h3C, 0);
        idle(1); #1;
        chk("3c_dout", dout_m, 8'h3C);
        send_word(8'hC3, 0);
        idle(1); #1;
        chk("c3_ovf", ovf_m, 1'b1);
        chk("c3_held", dout_m, 8'h3C);
        idle(1); #1;
        chk("c3_ovf_pulse", ovf_m, 1'b0);
        dout_rdy = 1'b1;
        idle(1); #1;
        chk("3c_drained", vld_m, 1'b0);
        idle(2); #1;
        chk("no_c3", vld_m, 1'b0);

        f0 = ferr_seen;
        send_partial(3);
        send_word(8'h5A, 0);
        idle(1); #1;
        chk("5a_dout", dout_m, 8'h5A);
        chk("5a_ferr_cnt", ferr_seen - f0, 1);
        idle(1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sin = 1'b1; sof = 1'b0; sin_vld = 1'b1;
        end
        idle(1); #1;
        chk("idle_ignore", busy_m, 1'b0);
        send_word(8'h81, 2);
        idle(1); #1;
        chk("81_gaps", dout_m, 8'h81);
        idle(1);

        dout_rdy = 1'b0;
        send_word(8'h11, 0);
        send_partial(5);
        @(negedge clk);
        rstn = 1'b0; sin_vld = 1'b0; sof = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_dout", dout_m, 8'h00);
        chk("rst_mid_vld", vld_m, 1'b0);
        chk("rst_mid_busy", busy_m, 1'b0);
        chk("rst_mid_ovf", ovf_m, 1'b0);
        chk("rst_mid_ferr", fe_m, 1'b0);
        rstn = 1'b1;
        dout_rdy = 1'b1;
        send_word(8'hF0, 0);
        idle(1); #1;
        chk("f0_dout", dout_m, 8'hF0);
        chk("f0_lsb", dout_l, 8'h0F);

        repeat (3000) begin
            @(negedge clk);
            sin_vld  = ($urandom_range(0, 3) != 0);
            sin      = 1'($urandom);
            sof      = ($urandom_range(0, 9) == 0);
            dout_rdy = ($urandom_range(0, 2) != 0);
            rstn     = ($urandom_range(0, 199) != 0);
        end
        rstn = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
